buffer_feed_sequencer: RTL
==========================

Name: buffer_feed_sequencer

Overview:
- Synthesizable, parametrised stream driver that writes one CNN input buffer (IFmap, filter or psum) from an internal word store, following a programmable write/skip slot schedule.
- Generalises the hand-written bench feeding loops: ready handshake, skip gaps, and optional end-of-stream flush words (start-tag / end-tag pattern) for draining the last psum.
- Sits between a host loader and the buffer's `*_in` / `*_write_enable` / `*_ready` port trio.
- One instance is used per buffer.

Parameters:
- DATA_WIDTH, 18, buffer word width; the top two bits are the row start/end tags for IFmap use.
- DEPTH, 32, number of words in the internal store.
- ADDR_WIDTH, $clog2(DEPTH), store address width.
- SLOT_MAX, 32, maximum schedule length (slots).
- GAP_CYCLES, 50, idle cycles consumed by one skip slot; must be >= 1.
- FLUSH_LEN, 4, number of flush words; must be >= 1.
- CNT_WIDTH, $clog2(SLOT_MAX+1), width of the count fields.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run.
- word_count  in  ADDR_WIDTH+1  number of store words to send; sampled at start.
- slot_count  in  CNT_WIDTH  schedule length; sampled at start; clamped to SLOT_MAX.
- skip_mask  in  SLOT_MAX  bit i=1 means slot i is a skip; sampled at start.
- flush_en  in  1  append the flush sequence after the schedule; sampled at start.
- load_wen  in  1  store write strobe.
- load_addr  in  ADDR_WIDTH  store write address.
- load_data  in  DATA_WIDTH  store write data.
- out_data  out  DATA_WIDTH  word presented to the buffer.
- out_wen  out  1  buffer write enable.
- out_ready  in  1  buffer ready; a transfer occurs on a rising edge where out_wen=1 and out_ready=1.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run ends.
- words_sent  out  ADDR_WIDTH+1  count of accepted store words in the current or last run.

Behaviour:
- Reset: every output is 0, state is IDLE, slot and word indices are 0. Store contents are not cleared.
- Reset mid-run: returns to IDLE on the next edge. out_wen drops on that edge; no partial transfer is counted.
- Store writes: load_wen is accepted only in IDLE; it is ignored while busy.
- Start: start is ignored unless in IDLE. On start in IDLE, the config inputs are latched, busy=1 the next cycle, and state goes to SLOT.
- SLOT, with slot index s < slot_count:
  - skip_mask[s]=1 → GAP.
  - Otherwise, if word_idx < word_count → WRITE, with out_data=store[word_idx] and out_wen=1 registered, so both are visible the cycle after SLOT.
  - Otherwise (store words exhausted) the slot is consumed as a no-op costing 1 cycle.
- WRITE: out_wen and out_data are held stable until out_ready=1 is sampled. On that edge, words_sent and word_idx increment, out_wen deasserts, and state goes to HOLD. There is no timeout.
- HOLD: exactly 1 idle cycle (out_wen=0), then s++ and return to SLOT.
- GAP: out_wen=0 for exactly GAP_CYCLES cycles, then s++ and return to SLOT.
- Schedule end (s == slot_count): if flush_en=1 → FLUSH; otherwise → DONE.
- FLUSH, word f = 0..FLUSH_LEN-1:
  - Bit DATA_WIDTH-1 = (f==0); bit DATA_WIDTH-2 = (f==FLUSH_LEN-1); all other bits 0.
  - FLUSH_LEN=1 gives both tag bits set.
  - Each flush word uses the same WRITE handshake plus a 1-cycle HOLD.
  - Flush words do not increment words_sent.
- DONE: a 1-cycle state. done=1, busy=0 from the same edge, then → IDLE. words_sent holds its value until the next start, which clears it.
- slot_count=0: with flush_en=0, done pulses 2 cycles after start; with flush_en=1, flush begins immediately.
- out_ready high continuously: each written word costs 3 cycles (SLOT, WRITE, HOLD).
- out_data holds its last value when out_wen=0. The value in that case is don't-care for checking.

Test Plan:
- Load 16 words 0x00001..0x00010, slot_count=18, skip_mask bits 2 and 10 set, flush_en=1, out_ready tied 1 → 20 out_wen transfers: the 16 words in order, then 0x20000, 0, 0, 0x10000. words_sent=16. The gaps between transfer 2/3 and 9/10 are each >= 50 cycles. Exactly one done pulse.
- Same stimulus, but out_ready low for 7 cycles during word 5 → out_wen and out_data are held stable for all 7 cycles. Word 5 is transferred exactly once and the sequence is otherwise identical.
- word_count=3, slot_count=6, mask=0, flush_en=0 → exactly 3 transfers, 3 no-op slots, then done. words_sent=3.
- FLUSH_LEN=1, slot_count=0, flush_en=1 → a single transfer of 0x30000, then done.
- Assert reset 2 cycles into GAP → next edge: busy=0, out_wen=0, done=0. A new start then replays from word 0 with words_sent cleared.
- start pulsed while busy, and load_wen to address 0 while busy → both ignored. Store word 0 is unchanged, and the run's transfer sequence is identical to an undisturbed run.

Source files
------------

// File: rtl/buffer_feed_sequencer_if.sv
// Buffer write port trio: word, write enable, and the buffer's ready back.
interface buffer_feed_sequencer_if #(
  parameter int DATA_WIDTH = 18
) ();
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_wen;
  logic                  out_ready;

  modport master (output out_data, output out_wen, input out_ready);
  modport slave  (input out_data, input out_wen, output out_ready);
endinterface

// File: rtl/buffer_feed_sequencer.sv
// Stream driver for one CNN input buffer: plays stored words out through a
// write/skip slot schedule, then optionally appends tagged flush words.
module buffer_feed_sequencer #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int SLOT_MAX   = 32,
  parameter int GAP_CYCLES = 50,
  parameter int FLUSH_LEN  = 4,
  parameter int CNT_WIDTH  = $clog2(SLOT_MAX+1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH:0]     word_count,
  input  logic [CNT_WIDTH-1:0]    slot_count,
  input  logic [SLOT_MAX-1:0]     skip_mask,
  input  logic                    flush_en,
  input  logic                    load_wen,
  input  logic [ADDR_WIDTH-1:0]   load_addr,
  input  logic [DATA_WIDTH-1:0]   load_data,
  buffer_feed_sequencer_if.master bif,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     words_sent
);

  localparam int SIDX_W = (SLOT_MAX > 1) ? $clog2(SLOT_MAX) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES+1) : 1;
  localparam int FL_W   = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN+1) : 1;

  typedef enum logic [2:0] {
    IDLE, SLOT, WRITE, HOLD, GAP, FLUSH, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH:0]     wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]    scnt_q, scnt_d;
  logic [SLOT_MAX-1:0]     mask_q, mask_d;
  logic                    flush_q, flush_d;
  logic                    in_flush_q, in_flush_d;
  logic [CNT_WIDTH-1:0]    s_q, s_d;
  logic [ADDR_WIDTH:0]     w_q, w_d;
  logic [FL_W-1:0]         f_q, f_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [ADDR_WIDTH:0]     sent_q, sent_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   flush_word;

  logic [DATA_WIDTH-1:0]   store [DEPTH];

  // Word store: host writes land only while idle so a run sees a frozen image.
  always_ff @(posedge clk) begin
    if (load_wen && state_q == IDLE) store[load_addr] <= load_data;
  end

  // Flush word f: start tag on the first, end tag on the last, payload zero.
  always_comb begin
    flush_word                 = '0;
    flush_word[DATA_WIDTH-1]   = (f_q == '0);
    flush_word[DATA_WIDTH-2]   = (f_q == FL_W'(FLUSH_LEN-1));
  end

  // Sequencer next state: slot walk, write handshake, gaps and flush tail.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    mask_d     = mask_q;
    flush_d    = flush_q;
    in_flush_d = in_flush_q;
    s_d        = s_q;
    w_d        = w_q;
    f_d        = f_q;
    gap_d      = gap_q;
    sent_d     = sent_q;
    data_d     = data_q;
    wen_d      = wen_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          wcnt_d     = word_count;
          scnt_d     = (slot_count > CNT_WIDTH'(SLOT_MAX)) ? CNT_WIDTH'(SLOT_MAX) : slot_count;
          mask_d     = skip_mask;
          flush_d    = flush_en;
          in_flush_d = 1'b0;
          s_d        = '0;
          w_d        = '0;
          f_d        = '0;
          gap_d      = '0;
          sent_d     = '0;
          state_d    = SLOT;
        end
      end
      SLOT: begin
        if (s_q < scnt_q) begin
          if (mask_q[s_q[SIDX_W-1:0]]) begin
            gap_d   = '0;
            state_d = GAP;
          end else if (w_q < wcnt_q) begin
            data_d  = store[w_q[ADDR_WIDTH-1:0]];
            wen_d   = 1'b1;
            state_d = WRITE;
          end else begin
            // store exhausted: slot burns one cycle as a no-op
            s_d = s_q + 1'b1;
          end
        end else if (flush_q) begin
          in_flush_d = 1'b1;
          f_d        = '0;
          state_d    = FLUSH;
        end else begin
          state_d = DONE;
        end
      end
      FLUSH: begin
        if (f_q < FL_W'(FLUSH_LEN)) begin
          data_d  = flush_word;
          wen_d   = 1'b1;
          state_d = WRITE;
        end else begin
          state_d = DONE;
        end
      end
      WRITE: begin
        // word and strobe stay put until the buffer takes them
        if (bif.out_ready) begin
          wen_d = 1'b0;
          if (!in_flush_q) begin
            sent_d = sent_q + 1'b1;
            w_d    = w_q + 1'b1;
          end
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (in_flush_q) begin
          f_d     = f_q + 1'b1;
          state_d = FLUSH;
        end else begin
          s_d     = s_q + 1'b1;
          state_d = SLOT;
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES-1)) begin
          gap_d   = '0;
          s_d     = s_q + 1'b1;
          state_d = SLOT;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      DONE: begin
        in_flush_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any run and drops the strobe at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      scnt_q     <= '0;
      mask_q     <= '0;
      flush_q    <= 1'b0;
      in_flush_q <= 1'b0;
      s_q        <= '0;
      w_q        <= '0;
      f_q        <= '0;
      gap_q      <= '0;
      sent_q     <= '0;
      data_q     <= '0;
      wen_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      scnt_q     <= scnt_d;
      mask_q     <= mask_d;
      flush_q    <= flush_d;
      in_flush_q <= in_flush_d;
      s_q        <= s_d;
      w_q        <= w_d;
      f_q        <= f_d;
      gap_q      <= gap_d;
      sent_q     <= sent_d;
      data_q     <= data_d;
      wen_q      <= wen_d;
    end
  end

  assign bif.out_data = data_q;
  assign bif.out_wen  = wen_q;
  assign busy         = (state_q != IDLE) && (state_q != DONE);
  assign done         = (state_q == DONE);
  assign words_sent   = sent_q;

endmodule
